keypad_scan: RTL
================

# keypad_scan

Matrix-keypad scanner for the 4×4 keypad on the display board. It drives the rows one at a time, samples the active-low columns, and debounces whole-keypad frames. It then presents a clean 16-bit one-hot key code. The block sits directly upstream of the one-hot-to-BCD encoder, whose `onehot[15:0]` input it feeds.

## Interface
- `SCAN_DIV`, default 5000: clock cycles each row is driven. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical frame comparisons required before a frame is committed. Must be ≥ 1.
- `clk  input  1`: system clock; all logic is on its rising edge.
- `rst_n  input  1`: reset, synchronous, active-low.
- `row  output  4`: row drive, active-low; exactly one bit is low at any time.
- `col  input  4`: column sense, active-low; pulled up off-chip.
- `onehot  output  16`: debounced key code, with bit index = 4·row_idx + col_idx. It is 0 when no key is pressed or when the frame is illegal.
- `key_valid  output  1`: one-cycle pulse when `onehot` changes to a new non-zero value.
- `key_held  output  1`: high while `onehot` ≠ 0.

## Operation
- **Reset values**
  - `row` = 4'b1110, `row_idx` = 0, slot counter = 0.
  - Frame accumulator, previous frame and `stable_cnt` = 0.
  - `onehot` = 0, `key_valid` = 0, `key_held` = 0.
- **Scan FSM**: states `DRIVE` → `SAMPLE` → `NEXT`.
  - `DRIVE`: slot counter runs 0 … SCAN_DIV-2 with row `row_idx` held low.
  - `SAMPLE`: the slot counter reaches SCAN_DIV-1. Store the inverted synchronised `col` into accumulator bits [4·row_idx+3 : 4·row_idx].
  - `NEXT`: this is the same cycle as the last slot cycle, not an extra cycle. Increment `row_idx` with wrap 3→0 and rotate `row` left (1110→1101→1011→0111→1110).
- **Frame end**: a frame ends at the SAMPLE of `row_idx` = 3.
  - If the new frame equals the previous frame, `stable_cnt` increments and saturates at DEBOUNCE_FRAMES. Otherwise `stable_cnt` is cleared to 0.
  - The previous frame is then loaded with the new frame.
- **Commit**: happens when `stable_cnt` becomes DEBOUNCE_FRAMES on this frame end.
  - Frame has exactly one bit set: `onehot` = frame.
  - Frame is zero, or has ≥ 2 bits set (ghosting / multi-key): `onehot` = 0.
  - `key_held` = (new `onehot` ≠ 0).
  - `key_valid` pulses if the new `onehot` ≠ 0 and differs from the old `onehot`.
- **Saturation**: while `stable_cnt` stays saturated, no recommit occurs, so a held key gives exactly one `key_valid`.
- **Release**: a release debounces the same way and clears `onehot` without a `key_valid` pulse.
- **Key change**: going from key A directly to key B (no zero frame committed in between) pulses `key_valid` for B.
- **Reset mid-scan**: reset aborts the frame. The partial accumulator is discarded and scanning restarts at row 0 on the next cycle.

## Timing
- Row slot = SCAN_DIV cycles; frame = 4·SCAN_DIV cycles.
- `col` is sampled on the last cycle of the slot. Input-to-sample latency is 1 cycle, or 2 cycles with the synchroniser enabled. SCAN_DIV ≥ 4 guarantees the row drive has settled before sampling.
- Commit latency: a key stable across frames F0 … F(DEBOUNCE_FRAMES) is committed at the end of frame F(DEBOUNCE_FRAMES).
- `onehot`, `key_held` and `key_valid` update on the clock edge following the final SAMPLE of the frame.
- `key_valid` is high for exactly 1 cycle.

## Configuration
- `KEYPAD_SYNC2_EN`
  - Defined: `col` passes through a 2-flop synchroniser before sampling.
  - Undefined: a single input register; input-to-sample latency is 1 cycle.
  - All other behaviour is identical either way.

## Structure
- Shared package `keypad_pkg`:
  - Constants `KP_ROWS` = 4, `KP_COLS` = 4, `KP_KEYS` = 16.
  - Scan-state enum `kp_state_t` {DRIVE, SAMPLE, NEXT}.
  - Function `kp_onehot_ok`, which returns true when exactly one bit is set.
- One sub-module, `kp_col_sync`: the column input register/synchroniser, with its depth selected by `KEYPAD_SYNC2_EN`.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles).
- After reset, idle with `col`=4'hF → `row` cycles 1110,1101,1011,0111 every 4 cycles; `onehot`=0 and `key_valid`=0 throughout.
- Key at row 2 / col 1 held (col=4'b1101 while row=1011) for 8 frames → `onehot`=16'h0200 at the 4th full frame end, `key_held`=1, exactly one `key_valid` pulse.
- Bounce: toggle that key every 10 cycles for 100 cycles, then leave it open → `onehot` stays 0 and no `key_valid`.
- Keys (0,3) and (1,0) held together for 6 frames → `onehot`=0, `key_held`=0, no `key_valid`.
- Hold key 9, then switch directly to key index 3 → `onehot` 16'h0200 → 16'h0008 with two `key_valid` pulses total. Then release → `onehot`=0 after 4 frames with no pulse.
- Assert `rst_n`=0 mid-frame while a key is committed → next cycle `row`=1110 and `onehot`=0. Recommit requires 4 full frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, scan-state type and helpers
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = 16;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    NEXT
  } kp_state_t;

  function automatic logic kp_onehot_ok(
    input logic [KP_KEYS-1:0] v
  );
    logic [KP_KEYS-1:0] m;
    m = v - KP_KEYS'(1);
    return (v != '0) && ((v & m) == '0);
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// kp_col_sync: column input register; two-flop synchroniser
// when KEYPAD_SYNC2_EN is defined, single register otherwise.
module kp_col_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_i,
  output logic [3:0] col_o
);

`ifdef KEYPAD_SYNC2_EN
  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  // two-stage shift of the raw column lines
  always_comb begin
    meta_d = col_i;
    sync_d = meta_q;
  end

  // synchroniser flops, idle (released) after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end
`else
  logic [3:0] sync_q, sync_d;

  // single capture of the raw column lines
  always_comb begin
    sync_d = col_i;
  end

  // input register, idle (released) after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end
`endif

  assign col_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad row scanner with frame debounce.
// Optional 2-flop column synchroniser: KEYPAD_SYNC2_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_PRE = SW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  kp_state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] prev_q, prev_d;
  logic [CW-1:0] stable_q, stable_d;
  logic [15:0] onehot_q, onehot_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [3:0]  col_s;
  logic        sample;
  logic        frame_end;
  logic [15:0] code;

  kp_col_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .col_i (col),
    .col_o (col_s)
  );

  // slot timing: DRIVE until the last slot cycle, then SAMPLE
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + SW'(1);
    unique case (state_q)
      DRIVE: begin
        if (slot_q == SLOT_PRE) state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = DRIVE;
        slot_d  = '0;
      end
      default: begin
        state_d = DRIVE;
        slot_d  = '0;
      end
    endcase
  end

  assign sample    = (state_q == SAMPLE);
  assign frame_end = sample && (row_idx_q == 2'd3);

  // capture columns into the frame and step to the next row
  always_comb begin
    acc_d     = acc_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    if (sample) begin
      acc_d[{row_idx_q, 2'b00} +: 4] = ~col_s;
      row_d     = {row_q[2:0], row_q[3]};
      row_idx_d = row_idx_q + 2'd1;
    end
  end

  // frame compare, debounce count and commit of the key code
  always_comb begin
    stable_d = stable_q;
    prev_d   = prev_q;
    onehot_d = onehot_q;
    held_d   = held_q;
    valid_d  = 1'b0;
    code     = kp_onehot_ok(acc_d) ? acc_d : '0;
    if (frame_end) begin
      if (acc_d != prev_q) begin
        stable_d = '0;
      end else if (stable_q != CNT_MAX) begin
        stable_d = stable_q + CW'(1);
      end
      prev_d = acc_d;
      if (stable_q != CNT_MAX && stable_d == CNT_MAX) begin
        onehot_d = code;
        held_d   = (code != '0);
        valid_d  = (code != '0) && (code != onehot_q);
      end
    end
  end

  // all state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DRIVE;
      slot_q    <= '0;
      row_idx_q <= '0;
      row_q     <= 4'b1110;
      acc_q     <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      acc_q     <= acc_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign row       = row_q;
  assign onehot    = onehot_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
